// File: rtl/uart_cmd_pkg.sv
// ============================================================================
// uart_cmd_pkg : opcodes, command/state encodings and frame-list helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_cmd_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [1:0] {
    TYPE_WR      = 2'b00,
    TYPE_RD      = 2'b01,
    TYPE_ALU_OP  = 2'b10,
    TYPE_ALU_NOP = 2'b11
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GAP    = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } frame_state_e;

  function automatic logic [7:0] cmd_opcode(input cmd_type_e t);
    logic [7:0] op;
    op = CMD_WR;
    case (t)
      TYPE_WR:      op = CMD_WR;
      TYPE_RD:      op = CMD_RD;
      TYPE_ALU_OP:  op = CMD_ALU_OP;
      TYPE_ALU_NOP: op = CMD_ALU_NOP;
      default:      op = CMD_WR;
    endcase
    return op;
  endfunction

  // Index of the final frame: frame count minus one (counts are 2..4).
  function automatic logic [1:0] cmd_last_idx(input cmd_type_e t);
    logic [1:0] idx;
    idx = 2'd1;
    case (t)
      TYPE_WR:      idx = 2'd2;
      TYPE_RD:      idx = 2'd1;
      TYPE_ALU_OP:  idx = 2'd3;
      TYPE_ALU_NOP: idx = 2'd1;
      default:      idx = 2'd1;
    endcase
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_cmd_tx_if.sv
// ============================================================================
// uart_cmd_tx_if : command request handshake between host master and uart_cmd_tx
// Rev 1.0
// ============================================================================
`default_nettype none

interface uart_cmd_tx_if
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  cmd_type_e             cmd_type;
  logic [DATA_WIDTH-1:0] cmd_arg0;
  logic [DATA_WIDTH-1:0] cmd_arg1;
  logic [DATA_WIDTH-1:0] cmd_arg2;
  logic                  par_en;
  logic                  par_typ;

  modport master (
    output cmd_valid, cmd_type, cmd_arg0, cmd_arg1, cmd_arg2, par_en, par_typ,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_arg0, cmd_arg1, cmd_arg2, par_en, par_typ,
    output cmd_ready
  );
endinterface

`default_nettype wire

// File: rtl/uart_frame_tx.sv
// ============================================================================
// uart_frame_tx : single-frame serializer GAP/START/DATA/PARITY/STOP
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_frame_tx
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_valid,
  input  logic [DATA_WIDTH-1:0] frame_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  frame_done,
  output logic                  tx
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(PRESCALE - 1);
  localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(DATA_WIDTH - 1);

  frame_state_e          r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par;
  logic                  r_par_en;
  logic                  r_tx;

  logic w_cnt_last;
  logic w_load;

  assign w_cnt_last = (r_cnt == c_cnt_last);
  // Final cycle of STOP: a queued frame loads here so its GAP follows seamlessly.
  assign frame_done = (r_state == ST_STOP) && w_cnt_last;
  assign w_load     = frame_valid && ((r_state == ST_IDLE) || frame_done);
  assign tx         = r_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_par_en <= 1'b0;
      r_tx     <= 1'b1;
    end else if (w_load) begin
      r_state  <= ST_GAP;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= frame_data;
      r_par    <= par_typ ? ~^frame_data : ^frame_data;
      r_par_en <= par_en;
      r_tx     <= 1'b1;
    end else if (r_state != ST_IDLE) begin
      if (!w_cnt_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
        case (r_state)
          ST_GAP: begin
            r_state <= ST_START;
            r_tx    <= 1'b0;
          end
          ST_START: begin
            r_state <= ST_DATA;
            r_bit   <= '0;
            r_tx    <= r_shift[0];
          end
          ST_DATA: begin
            if (r_bit == c_bit_last) begin
              if (r_par_en) begin
                r_state <= ST_PARITY;
                r_tx    <= r_par;
              end else begin
                r_state <= ST_STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit   <= r_bit + BIT_W'(1);
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end
          ST_PARITY: begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end
          default: begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_cmd_tx.sv
// ============================================================================
// uart_cmd_tx : latches one command and sequences its opcode/argument frames
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_cmd_tx
  import uart_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 32
) (
  input  logic          uart_clk,
  input  logic          rst,
  uart_cmd_tx_if.slave  cmd,
  output logic          tx_out,
  output logic          busy,
  output logic          cmd_done
);

  logic                  r_ready;
  logic                  r_busy;
  logic                  r_done;
  logic [1:0]            r_idx;
  logic [1:0]            r_last;
  cmd_type_e             r_type;
  logic [DATA_WIDTH-1:0] r_arg0;
  logic [DATA_WIDTH-1:0] r_arg1;
  logic [DATA_WIDTH-1:0] r_arg2;
  logic                  r_par_en;
  logic                  r_par_typ;

  logic                  w_frame_done;
  logic                  w_cmd_end;
  logic                  w_next;
  logic                  w_accept;
  logic                  w_frame_valid;
  logic [1:0]            w_next_idx;
  logic [DATA_WIDTH-1:0] w_seq_byte;
  logic [DATA_WIDTH-1:0] w_frame_data;
  logic                  w_frame_par_en;
  logic                  w_frame_par_typ;

  assign w_cmd_end  = r_busy && w_frame_done && (r_idx == r_last);
  assign w_next     = r_busy && w_frame_done && (r_idx != r_last);
  // Ready also covers the final stop cycle so a waiting command starts on the done edge.
  assign cmd.cmd_ready = r_ready || w_cmd_end;
  assign w_accept      = cmd.cmd_valid && cmd.cmd_ready;
  assign w_frame_valid = w_accept || w_next;
  assign w_next_idx    = r_idx + 2'd1;

  always_comb begin
    w_seq_byte = r_arg0;
    case (r_type)
      TYPE_WR:      w_seq_byte = (w_next_idx == 2'd1) ? r_arg0 : r_arg1;
      TYPE_RD:      w_seq_byte = r_arg0;
      TYPE_ALU_OP: begin
        if (w_next_idx == 2'd1)      w_seq_byte = r_arg0;
        else if (w_next_idx == 2'd2) w_seq_byte = r_arg1;
        else                         w_seq_byte = r_arg2;
      end
      TYPE_ALU_NOP: w_seq_byte = r_arg2;
      default:      w_seq_byte = r_arg0;
    endcase
  end

  assign w_frame_data    = w_accept ? DATA_WIDTH'(cmd_opcode(cmd.cmd_type)) : w_seq_byte;
  assign w_frame_par_en  = w_accept ? cmd.par_en  : r_par_en;
  assign w_frame_par_typ = w_accept ? cmd.par_typ : r_par_typ;

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_idx     <= 2'd0;
      r_last    <= 2'd0;
      r_type    <= TYPE_WR;
      r_arg0    <= '0;
      r_arg1    <= '0;
      r_arg2    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
    end else begin
      r_done <= w_cmd_end;
      if (w_accept) begin
        r_ready   <= 1'b0;
        r_busy    <= 1'b1;
        r_idx     <= 2'd0;
        r_last    <= cmd_last_idx(cmd.cmd_type);
        r_type    <= cmd.cmd_type;
        r_arg0    <= cmd.cmd_arg0;
        r_arg1    <= cmd.cmd_arg1;
        r_arg2    <= cmd.cmd_arg2;
        r_par_en  <= cmd.par_en;
        r_par_typ <= cmd.par_typ;
      end else if (w_cmd_end) begin
        r_ready <= 1'b1;
        r_busy  <= 1'b0;
      end else if (w_next) begin
        r_idx <= w_next_idx;
      end
    end
  end

  uart_frame_tx #(
    .DATA_WIDTH (DATA_WIDTH),
    .PRESCALE   (PRESCALE)
  ) u_frame_tx (
    .clk         (uart_clk),
    .rst         (rst),
    .frame_valid (w_frame_valid),
    .frame_data  (w_frame_data),
    .par_en      (w_frame_par_en),
    .par_typ     (w_frame_par_typ),
    .frame_done  (w_frame_done),
    .tx          (tx_out)
  );

  assign busy     = r_busy;
  assign cmd_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_tx.sv
// ============================================================================
// tb_uart_cmd_tx : line-level model, UART receiver and directed command tests
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_cmd_tx;
  import uart_cmd_pkg::*;

  localparam int DW = 8;
  localparam int P  = 32;

  logic clk = 1'b0;
  logic rst;
  logic tx_out, busy, cmd_done;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  uart_cmd_tx_if #(.DATA_WIDTH(DW)) cmd_if ();

  uart_cmd_tx #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
    .uart_clk (clk),
    .rst      (rst),
    .cmd      (cmd_if),
    .tx_out   (tx_out),
    .busy     (busy),
    .cmd_done (cmd_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected line level for every cycle of the current command.
  bit mq[$];
  bit m_in_cmd = 1'b0;
  bit m_done   = 1'b0;
  bit m_tx     = 1'b1;
  bit m_acc;

  task automatic push_bits(input bit v, input int n);
    for (int i = 0; i < n; i++) mq.push_back(v);
  endtask

  task automatic push_frame(input logic [7:0] b, input bit pen, input bit ptyp);
    push_bits(1'b1, P);
    push_bits(1'b0, P);
    for (int i = 0; i < 8; i++) push_bits(b[i], P);
    if (pen) push_bits(ptyp ? ~^b : ^b, P);
    push_bits(1'b1, P);
  endtask

  task automatic model_accept();
    logic [7:0] a0, a1, a2;
    bit pen, pt;
    a0 = cmd_if.cmd_arg0; a1 = cmd_if.cmd_arg1; a2 = cmd_if.cmd_arg2;
    pen = cmd_if.par_en;  pt = cmd_if.par_typ;
    case (cmd_if.cmd_type)
      TYPE_WR:     begin push_frame(8'hAA, pen, pt); push_frame(a0, pen, pt); push_frame(a1, pen, pt); end
      TYPE_RD:     begin push_frame(8'hBB, pen, pt); push_frame(a0, pen, pt); end
      TYPE_ALU_OP: begin push_frame(8'hCC, pen, pt); push_frame(a0, pen, pt);
                         push_frame(a1, pen, pt); push_frame(a2, pen, pt); end
      default:     begin push_frame(8'hDD, pen, pt); push_frame(a2, pen, pt); end
    endcase
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_in_cmd = 1'b0;
      m_done   = 1'b0;
      m_tx     = 1'b1;
    end else begin
      m_acc  = cmd_if.cmd_valid && (!m_in_cmd || mq.size() == 0);
      m_done = m_in_cmd && mq.size() == 0;
      if (m_done) m_in_cmd = 1'b0;
      if (m_acc) begin
        model_accept();
        m_in_cmd = 1'b1;
      end
      m_tx = (mq.size() > 0) ? mq.pop_front() : 1'b1;
    end
    #1;
    check("tx_out",    32'(tx_out),           32'(m_tx));
    check("busy",      32'(busy),             32'(m_in_cmd));
    check("cmd_ready", 32'(cmd_if.cmd_ready), 32'(!m_in_cmd || mq.size() == 0));
    check("cmd_done",  32'(cmd_done),         32'(m_done));
  end

  // Mid-bit sampling receiver: {parity, byte} per frame.
  logic [8:0] rxq[$];
  bit         rx_pen = 1'b0;
  logic [7:0] rx_b;
  logic       rx_p;
  initial begin
    forever begin
      @(posedge clk); #2;
      if (rst === 1'b0 && tx_out === 1'b0) begin
        repeat (P/2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (P) @(posedge clk); #2;
          rx_b[i] = tx_out;
        end
        rx_p = 1'b0;
        if (rx_pen) begin
          repeat (P) @(posedge clk); #2;
          rx_p = tx_out;
        end
        repeat (P) @(posedge clk);
        rxq.push_back({rx_p, rx_b});
      end
    end
  end

  task automatic check_rx(input string name, input int n,
                          input logic [8:0] e0, e1, e2, e3);
    logic [8:0] e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check({name, "_count"}, rxq.size(), n);
    for (int i = 0; i < n; i++)
      check(name, (i < rxq.size()) ? 32'(rxq[i]) : 32'hFFFF, 32'(e[i]));
  endtask

  task automatic drive(input cmd_type_e t, input logic [7:0] a0, a1, a2, input bit pen, pt);
    cmd_if.cmd_type = t;
    cmd_if.cmd_arg0 = a0;
    cmd_if.cmd_arg1 = a1;
    cmd_if.cmd_arg2 = a2;
    cmd_if.par_en   = pen;
    cmd_if.par_typ  = pt;
  endtask

  task automatic wait_done(input int bound, output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (cmd_done !== 1'b1 && cnt < bound);
  endtask

  task automatic run_cmd(input cmd_type_e t, input logic [7:0] a0, a1, a2,
                         input bit pen, pt, input string name, input int exp_len);
    int cnt;
    @(negedge clk);
    drive(t, a0, a1, a2, pen, pt);
    rx_pen = pen;
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    drive(TYPE_ALU_OP, ~a0, ~a1, ~a2, ~pen, ~pt);
    wait_done(exp_len + 64, cnt);
    check(name, cnt, exp_len);
  endtask

  int cnt, e_cyc, n_done;

  initial begin
    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    drive(TYPE_WR, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_tx",    32'(tx_out),           32'd1);
    check("reset_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check("reset_busy",  32'(busy),             32'd0);
    check("reset_done",  32'(cmd_done),         32'd0);

    rxq.delete();
    run_cmd(TYPE_WR, 8'h05, 8'hA6, 8'h00, 1'b1, PAR_EVEN, "wr_len", 1152);
    check_rx("wr_rx", 3, 9'h0AA, 9'h005, 9'h0A6, 9'h000);

    rxq.delete();
    run_cmd(TYPE_RD, 8'h05, 8'h00, 8'h00, 1'b1, PAR_ODD, "rd_len", 768);
    check_rx("rd_rx", 2, 9'h1BB, 9'h105, 9'h000, 9'h000);

    rxq.delete();
    run_cmd(TYPE_ALU_OP, 8'h28, 8'h1E, 8'h01, 1'b0, PAR_EVEN, "alu_len", 1408);
    check_rx("alu_rx", 4, 9'h0CC, 9'h028, 9'h01E, 9'h001);

    // Back-to-back: valid held high, second command taken on the done edge.
    rxq.delete();
    @(negedge clk);
    drive(TYPE_ALU_NOP, 8'h00, 8'h00, 8'h00, 1'b1, PAR_EVEN);
    rx_pen = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    drive(TYPE_RD, 8'h05, 8'h00, 8'h00, 1'b1, PAR_EVEN);
    wait_done(768 + 64, cnt);
    check("b2b_first_len", cnt, 768);
    e_cyc = cyc;
    check("b2b_busy_after_done", 32'(busy), 32'd1);
    cnt = 1;
    while (tx_out !== 1'b0 && cnt < 200) begin
      @(posedge clk); #1;
      if (tx_out !== 1'b0) cnt++;
    end
    check("b2b_high_gap", cnt, 32);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    repeat (40) @(negedge clk);
    drive(TYPE_WR, 8'h77, 8'h66, 8'h55, 1'b0, PAR_ODD);
    cmd_if.cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    wait_done(768, cnt);
    check("b2b_second_len", cyc - e_cyc, 768);
    check_rx("b2b_rx", 4, 9'h0DD, 9'h000, 9'h0BB, 9'h005);

    // Reset during DATA bits of frame 2.
    @(negedge clk);
    drive(TYPE_WR, 8'h11, 8'h22, 8'h00, 1'b1, PAR_EVEN);
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    repeat (384 + 3*P) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_tx",    32'(tx_out),           32'd1);
    check("midrst_ready", 32'(cmd_if.cmd_ready), 32'd1);
    check("midrst_busy",  32'(busy),             32'd0);
    check("midrst_done",  32'(cmd_done),         32'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (20*P) begin
      @(posedge clk); #1;
      if (cmd_done === 1'b1) n_done++;
    end
    check("midrst_no_done", n_done, 0);

    rxq.delete();
    run_cmd(TYPE_WR, 8'h3C, 8'hC3, 8'h00, 1'b1, PAR_EVEN, "wr2_len", 1152);
    check_rx("wr2_rx", 3, 9'h0AA, 9'h03C, 9'h0C3, 9'h000);

    repeat (4) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_cmd_tx.md
# uart_cmd_tx

Host-side UART command initiator: accepts one register-file or ALU command over a valid/ready handshake and serializes it as the multi-frame UART byte sequence that the system's UART command decoder consumes (0xAA write, 0xBB read, 0xCC ALU-with-operands, 0xDD ALU-no-operands). It lets an on-chip or FPGA-side master drive `SYS_TOP`'s `RX_IN` directly, replacing behavioural stimulus. It sits in the `UART_CLK` domain, and its `TX_OUT` wires to the system's `RX_IN`.

## Interface
- `DATA_WIDTH`, 8, frame payload width
- `PRESCALE`, 32, `UART_CLK` cycles per bit period (≥ 2)
- `UART_CLK`  in  1  UART clock; all logic on the rising edge
- `RST`  in  1  reset, synchronous, active-high
- `CMD_VALID`  in  1  command request
- `CMD_READY`  out  1  block idle and able to accept
- `CMD_TYPE`  in  2  00 WR, 01 RD, 10 ALU_OP, 11 ALU_NOP
- `CMD_ARG0`  in  DATA_WIDTH  WR/RD address, or ALU operand A
- `CMD_ARG1`  in  DATA_WIDTH  WR data, or ALU operand B
- `CMD_ARG2`  in  DATA_WIDTH  ALU function
- `PAR_EN`  in  1  parity bit enable
- `PAR_TYP`  in  1  0 even, 1 odd
- `TX_OUT`  out  1  serial line, idle high
- `BUSY`  out  1  command in progress
- `CMD_DONE`  out  1  one-cycle pulse after the final stop bit

## Operation
- Handshake: a command is accepted on a rising edge where `CMD_VALID & CMD_READY`. All `CMD_*`, `PAR_EN`, and `PAR_TYP` inputs are latched at acceptance. `CMD_VALID` while busy is ignored and is not queued.
- Frame lists:
  - WR: AA, ARG0, ARG1 (3 frames)
  - RD: BB, ARG0 (2 frames)
  - ALU_OP: CC, ARG0, ARG1, ARG2 (4 frames)
  - ALU_NOP: DD, ARG2 (2 frames)
- Frame format: GAP (1 bit period high), START (low), 8 data bits LSB first, optional PARITY, STOP (high).
- Parity: even = `^data`, odd = `~^data`.
- FSM states: IDLE → GAP → START → DATA (bit index 0..7) → PARITY (only if `PAR_EN`) → STOP.
  - After STOP, go to GAP if frames remain, otherwise return to IDLE.
  - Each non-IDLE state lasts exactly `PRESCALE` cycles, counted by a prescale counter from 0 to PRESCALE-1.
- Counters: prescale counter `$clog2(PRESCALE)` bits; bit index 3 bits; frame index 2 bits, compared against the latched frame count (2..4).
- Reset: on `RST` high, the next edge forces IDLE with `TX_OUT`=1, `CMD_READY`=1, `BUSY`=0, `CMD_DONE`=0. A frame in flight is truncated, the line returns high immediately, and nothing resumes.

## Timing
- `TX_OUT` is driven from a register, so it is glitch-free.
- Acceptance edge t0:
  - `CMD_READY`=0 and `BUSY`=1 from t0.
  - GAP spans t0..t0+PRESCALE.
  - `TX_OUT` falls at edge t0+PRESCALE.
- Bit k of a frame starting at edge s (the GAP start) is valid from edge s+(k+1)·PRESCALE.
- Frame length L = (11 + `PAR_EN`)·PRESCALE cycles. Command length = N_frames·L.
- At edge t0+N·L:
  - `CMD_DONE`=1 for exactly one cycle.
  - `CMD_READY`=1 and `BUSY`=0.
- A new command may be accepted on that same edge; its GAP begins at once, so back-to-back commands keep exactly one idle bit between frames.
- Reset values: `TX_OUT`=1, `CMD_READY`=1, `BUSY`=0, `CMD_DONE`=0.

## Structure
- Package `uart_cmd_pkg` holds:
  - opcode constants `CMD_WR`=8'hAA, `CMD_RD`=8'hBB, `CMD_ALU_OP`=8'hCC, `CMD_ALU_NOP`=8'hDD
  - the `CMD_TYPE` encoding enum
  - parity-type constants
  - the FSM state enum
- Sub-module `uart_frame_tx`: a single-frame serializer with GAP..STOP, the prescale and bit counters, and a `frame_valid`/`frame_done` handshake.
- The top level holds the command latch, frame sequencing, and the handshake.

## Test plan
- WR addr 0x05 data 0xA6, even parity, PRESCALE=32 → bytes AA, 05, A6, all with parity 0; `BUSY` for 1152 cycles; one `CMD_DONE` pulse; decoded by a bench UART receiver.
- RD addr 0x05, odd parity → BB with parity 1, then 05 with parity 1; total 768 cycles; `SYS_TOP` loopback returns 0xA6 after a prior write.
- ALU_OP 0x28, 0x1E, func 0x01, parity disabled → CC, 28, 1E, 01 as 11-bit frames; 1408 cycles; the system then returns 0x0A, 0x00.
- `CMD_VALID` held high across two commands (ALU_NOP func 0x00, then RD) → second command accepted on the `CMD_DONE` edge; exactly 32 high cycles between the first command's final stop bit and the next start bit; mid-command `VALID` toggles have no effect.
- `RST` asserted for 1 cycle during the DATA bits of frame 2 → next edge gives `TX_OUT`=1, `CMD_READY`=1, `BUSY`=0, and no `CMD_DONE`; a subsequent WR transmits cleanly.
